// File: rtl/raw10_pixel_serializer_if.sv
// Stream bundle between the RAW10 unpacker, the serializer and the ISP.
// Signal suffixes are from the serializer's point of view.
interface raw10_pixel_serializer_if;
   logic        in_valid_i;
   logic [39:0] in_data_i;
   logic        in_ready_o;
   logic        pix_valid_o;
   logic        pix_ready_i;
   logic [9:0]  pix_data_o;
   logic        pix_sol_o;
   logic        pix_eol_o;

   modport slave (
      input  in_valid_i,
      input  in_data_i,
      output in_ready_o,
      output pix_valid_o,
      input  pix_ready_i,
      output pix_data_o,
      output pix_sol_o,
      output pix_eol_o
   );

   modport master (
      output in_valid_i,
      output in_data_i,
      input  in_ready_o,
      input  pix_valid_o,
      output pix_ready_i,
      input  pix_data_o,
      input  pix_sol_o,
      input  pix_eol_o
   );
endinterface

// File: rtl/raw10_pixel_serializer.sv
// Buffers packed 4-pixel RAW10 words and emits one pixel per handshake.
// Define RAW10_SER_BLC_EN to add black-level subtraction on pix_data_o.
module raw10_pixel_serializer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LW_BITS    = 12
) (
   input  logic                         wb_clk_i,
   input  logic                         reset,
   input  logic                         enable_i,
   input  logic [LW_BITS-1:0]           line_width_i,
`ifdef RAW10_SER_BLC_EN
   input  logic [9:0]                   black_level_i,
`endif
   raw10_pixel_serializer_if.slave      bus,
   output logic [LW_BITS-1:0]           line_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
   output logic                         overflow_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [LW_BITS-1:0] LW_ONE = LW_BITS'(1);
   localparam logic [LW_BITS-1:0] LW_DEF = LW_BITS'(4);

   logic [39:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]        lvl_q, lvl_d;
   logic [1:0]         idx_q, idx_d;
   logic [LW_BITS-1:0] col_q, col_d;
   logic [LW_BITS-1:0] lw_q, lw_d;
   logic [LW_BITS-1:0] line_q, line_d;
   logic               ovf_q, ovf_d;

   logic               empty, full, valid, xfer, pop, push, drop, eol;
   logic [LW_BITS-1:0] lw_sel;
   logic [39:0]        head;
   logic [9:0]         raw;

   assign empty = (lvl_q == '0);
   assign full  = (lvl_q == FULL);
   assign valid = enable_i && !empty;
   assign xfer  = valid && bus.pix_ready_i;
   assign pop   = xfer && (idx_q == 2'd3);
   // A full FIFO still takes a word when the head leaves this cycle.
   assign push  = enable_i && bus.in_valid_i && (!full || pop);
   assign drop  = enable_i && bus.in_valid_i && !push;
   assign eol   = (col_q == lw_q - LW_ONE);
   assign head  = mem_q[rd_q];

   assign lw_sel = (line_width_i != '0 && line_width_i[1:0] == 2'b00)
                 ? line_width_i : LW_DEF;

   always_comb begin
      raw = head[39:30];
      unique case (idx_q)
         2'd0: raw = head[39:30];
         2'd1: raw = head[29:20];
         2'd2: raw = head[19:10];
         2'd3: raw = head[9:0];
      endcase
   end

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      lvl_d  = lvl_q;
      idx_d  = idx_q;
      col_d  = col_q;
      lw_d   = lw_q;
      line_d = line_q;
      ovf_d  = ovf_q;
      if (!enable_i) begin
         wr_d   = '0;
         rd_d   = '0;
         lvl_d  = '0;
         idx_d  = '0;
         col_d  = '0;
         line_d = '0;
         ovf_d  = 1'b0;
         lw_d   = lw_sel;
      end else begin
         if (push) wr_d = wr_q + 1'b1;
         if (pop)  rd_d = rd_q + 1'b1;
         lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
         if (xfer) begin
            idx_d = idx_q + 2'd1;
            col_d = eol ? '0 : col_q + LW_ONE;
            if (eol) line_d = line_q + LW_ONE;
         end
         if (drop) ovf_d = 1'b1;
         // Width is latched only between lines.
         if (col_q == '0) lw_d = lw_sel;
      end
   end

   always_ff @(posedge wb_clk_i or posedge reset) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         lvl_q  <= '0;
         idx_q  <= '0;
         col_q  <= '0;
         lw_q   <= LW_DEF;
         line_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         lvl_q  <= lvl_d;
         idx_q  <= idx_d;
         col_q  <= col_d;
         lw_q   <= lw_d;
         line_q <= line_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_q] <= bus.in_data_i;
   end

`ifdef RAW10_SER_BLC_EN
   assign bus.pix_data_o = (raw < black_level_i)
                         ? 10'd0 : raw - black_level_i;
`else
   assign bus.pix_data_o = raw;
`endif

   assign bus.pix_valid_o = valid;
   assign bus.pix_sol_o   = (col_q == '0);
   assign bus.pix_eol_o   = eol;
   assign bus.in_ready_o  = enable_i && !full;
   assign line_cnt_o      = line_q;
   assign fifo_level_o    = lvl_q;
   assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_raw10_pixel_serializer.sv
// Directed bench for raw10_pixel_serializer with a pixel scoreboard.
// Honours RAW10_SER_BLC_EN to exercise black-level subtraction.
module tb_raw10_pixel_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] lw;
   logic [11:0] line_cnt;
   logic [2:0]  level;
   logic        ovf;
   logic [9:0]  bl = 10'd0;

   int n_cmp = 0;
   int n_bad = 0;
   int mcol  = 0;

   logic [9:0] exp_d[$];
   logic       exp_s[$];
   logic       exp_e[$];

   raw10_pixel_serializer_if bus();

   raw10_pixel_serializer #(
      .FIFO_DEPTH(4),
      .LW_BITS(12)
   ) dut (
      .wb_clk_i(clk),
      .reset(reset),
      .enable_i(enable),
      .line_width_i(lw),
`ifdef RAW10_SER_BLC_EN
      .black_level_i(bl),
`endif
      .bus(bus.slave),
      .line_cnt_o(line_cnt),
      .fifo_level_o(level),
      .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [39:0] mkw(input logic [9:0] a, b, c, d);
      return {a, b, c, d};
   endfunction

   task automatic expect_word(input logic [39:0] w, input int lwid);
      logic [9:0] p;
      for (int i = 0; i < 4; i++) begin
         p = w[39-10*i -: 10];
`ifdef RAW10_SER_BLC_EN
         p = (p < bl) ? 10'd0 : p - bl;
`endif
         exp_d.push_back(p);
         exp_s.push_back(mcol == 0);
         exp_e.push_back(mcol == lwid - 1);
         mcol = (mcol == lwid - 1) ? 0 : mcol + 1;
      end
   endtask

   task automatic clear_model();
      exp_d.delete();
      exp_s.delete();
      exp_e.delete();
      mcol = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.pix_valid_o) begin
         if (exp_d.size() == 0) begin
            check("extra_pix", bus.pix_valid_o, 1'b0);
         end else begin
            check("pix_data", bus.pix_data_o, exp_d[0]);
            check("pix_sol", bus.pix_sol_o, exp_s[0]);
            check("pix_eol", bus.pix_eol_o, exp_e[0]);
            if (bus.pix_ready_i) begin
               void'(exp_d.pop_front());
               void'(exp_s.pop_front());
               void'(exp_e.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [39:0] w);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = w;
      tick();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic drain(input int maxc, input bit toggle);
      for (int i = 0; i < maxc && exp_d.size() != 0; i++) begin
         if (toggle) bus.pix_ready_i = ~bus.pix_ready_i;
         tick();
      end
      check("drain_left", exp_d.size(), 0);
   endtask

   task automatic flush(input logic [11:0] w);
      lw     = w;
      enable = 1'b0;
      tick();
      enable = 1'b1;
      clear_model();
   endtask

   logic [39:0] w0, w1, w2, w3, w4;

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      lw             = 12'd4;
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = '0;
      bus.pix_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_valid", bus.pix_valid_o, 1'b0);
      check("rst_ready", bus.in_ready_o, 1'b0);
      check("rst_level", level, 3'd0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_line", line_cnt, 12'd0);

      // single word, width 4
      flush(12'd4);
      bus.pix_ready_i = 1'b1;
      w0 = mkw(10'h3FF, 10'h000, 10'h155, 10'h2AA);
      expect_word(w0, 4);
      check("lat_pre", bus.pix_valid_o, 1'b0);
      push(w0);
      check("lat_n1", bus.pix_valid_o, 1'b1);
      repeat (4) tick();
      check("t1_left", exp_d.size(), 0);
      check("t1_line", line_cnt, 12'd1);
      check("t1_idle", bus.pix_valid_o, 1'b0);

      // width 8, toggled ready
      flush(12'd8);
      bus.pix_ready_i = 1'b0;
      w0 = mkw(10'h101, 10'h102, 10'h103, 10'h104);
      w1 = mkw(10'h105, 10'h106, 10'h107, 10'h108);
      expect_word(w0, 8);
      expect_word(w1, 8);
      push(w0);
      push(w1);
      drain(40, 1'b1);
      check("t2_line", line_cnt, 12'd1);

      // overflow with stalled output
      flush(12'd4);
      bus.pix_ready_i = 1'b0;
      w0 = mkw(10'h011, 10'h012, 10'h013, 10'h014);
      w1 = mkw(10'h021, 10'h022, 10'h023, 10'h024);
      w2 = mkw(10'h031, 10'h032, 10'h033, 10'h034);
      w3 = mkw(10'h041, 10'h042, 10'h043, 10'h044);
      w4 = mkw(10'h051, 10'h052, 10'h053, 10'h054);
      expect_word(w0, 4);
      expect_word(w1, 4);
      expect_word(w2, 4);
      expect_word(w3, 4);
      push(w0);
      push(w1);
      push(w2);
      push(w3);
      check("t3_ovf_pre", ovf, 1'b0);
      push(w4);
      check("t3_level", level, 3'd4);
      check("t3_ready", bus.in_ready_o, 1'b0);
      check("t3_ovf", ovf, 1'b1);
      bus.pix_ready_i = 1'b1;
      drain(40, 1'b0);
      check("t3_idle", bus.pix_valid_o, 1'b0);
      check("t3_empty", level, 3'd0);
      check("t3_sticky", ovf, 1'b1);

      // full FIFO, push while head pops
      flush(12'd4);
      check("t4_ovf_clr", ovf, 1'b0);
      bus.pix_ready_i = 1'b0;
      expect_word(w0, 4);
      expect_word(w1, 4);
      expect_word(w2, 4);
      expect_word(w3, 4);
      expect_word(w4, 4);
      push(w0);
      push(w1);
      push(w2);
      push(w3);
      bus.pix_ready_i = 1'b1;
      repeat (3) tick();
      push(w4);
      check("t4_level", level, 3'd4);
      check("t4_ovf", ovf, 1'b0);
      drain(40, 1'b0);
      check("t4_empty", level, 3'd0);

      // width change mid-line
      flush(12'd8);
      bus.pix_ready_i = 1'b0;
      expect_word(w0, 8);
      expect_word(w1, 8);
      expect_word(w2, 4);
      expect_word(w3, 4);
      push(w0);
      push(w1);
      push(w2);
      push(w3);
      bus.pix_ready_i = 1'b1;
      repeat (5) tick();
      lw = 12'd4;
      drain(40, 1'b0);
      check("t5_line", line_cnt, 12'd3);

      // async reset mid-line
      flush(12'd8);
      bus.pix_ready_i = 1'b0;
      expect_word(w0, 8);
      expect_word(w1, 8);
      expect_word(w2, 8);
      push(w0);
      push(w1);
      push(w2);
      bus.pix_ready_i = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      #1;
      check("t6_rst_valid", bus.pix_valid_o, 1'b0);
      check("t6_rst_level", level, 3'd0);
      clear_model();
      tick();
      reset = 1'b0;
      check("t6_rst_line", line_cnt, 12'd0);
      expect_word(w3, 8);
      push(w3);
      drain(20, 1'b0);

      // enable drop mid-line with inputs ignored
      flush(12'd8);
      bus.pix_ready_i = 1'b0;
      expect_word(w0, 8);
      expect_word(w1, 8);
      expect_word(w2, 8);
      push(w0);
      push(w1);
      push(w2);
      bus.pix_ready_i = 1'b1;
      repeat (2) tick();
      enable = 1'b0;
      clear_model();
      push(w4);
      check("t6_en_valid", bus.pix_valid_o, 1'b0);
      check("t6_en_level", level, 3'd0);
      check("t6_en_ready", bus.in_ready_o, 1'b0);
      enable = 1'b1;
      expect_word(w3, 8);
      push(w3);
      drain(20, 1'b0);
      check("t6_en_line", line_cnt, 12'd0);

`ifdef RAW10_SER_BLC_EN
      flush(12'd4);
      bl = 10'd64;
      bus.pix_ready_i = 1'b1;
      w0 = mkw(10'd100, 10'd10, 10'd64, 10'd1023);
      expect_word(w0, 4);
      push(w0);
      drain(10, 1'b0);
      bl = 10'd0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
